// File: rtl/ifu_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues one AR/R read at a time and hands {inst, pc, snpc} to D.
// Optional macro IFU_SKID_BUF_EN registers the response in a one-entry HOLD buffer so R is never stalled.
module ifu_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instF,
    output logic [31:0] pcF,
    output logic [31:0] snpcF,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        fetch_err
);

`ifdef IFU_SKID_BUF_EN
    typedef enum logic [1:0] {IDLE, ADDR, WAIT_R, HOLD} state_t;
`else
    typedef enum logic [1:0] {IDLE, ADDR, WAIT_R} state_t;
`endif

    state_t      state;
    logic [31:0] pc;
    logic [31:0] req_addr;
    logic        kill;
    logic        ar_hs;
    logic        r_hs;

    assign arvalid = (state == ADDR);
    assign araddr  = req_addr;
    assign ar_hs   = arvalid & arready;
    assign r_hs    = rvalid & rready;

`ifdef IFU_SKID_BUF_EN
    logic [31:0] inst_q;
    logic [31:0] pc_q;
    logic [31:0] snpc_q;
    logic        err_q;

    assign rready    = (state == WAIT_R);
    // A redirect hides the held entry immediately so it cannot be taken this cycle.
    assign m_valid   = (state == HOLD) & ~redirect_valid;
    assign instF     = inst_q;
    assign pcF       = pc_q;
    assign snpcF     = snpc_q;
    assign fetch_err = m_valid & m_ready & err_q;
`else
    // A killed response is drained regardless of D-stage readiness.
    assign rready    = (state == WAIT_R) & (kill | m_ready);
    assign m_valid   = (state == WAIT_R) & rvalid & ~kill & ~redirect_valid;
    assign instF     = rdata;
    assign pcF       = req_addr;
    assign snpcF     = req_addr + 32'd4;
    assign fetch_err = m_valid & m_ready & (rresp != 2'b00);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            kill     <= 1'b0;
`ifdef IFU_SKID_BUF_EN
            inst_q   <= 32'd0;
            pc_q     <= 32'd0;
            snpc_q   <= 32'd0;
            err_q    <= 1'b0;
`endif
        end else begin
            if (redirect_valid)
                pc <= redirect_pc;
            case (state)
                IDLE: begin
                    req_addr <= redirect_valid ? redirect_pc : pc;
                    state    <= ADDR;
                end
                ADDR: begin
                    // araddr is frozen until accepted; the stale fetch is dropped later.
                    if (redirect_valid)
                        kill <= 1'b1;
                    if (ar_hs)
                        state <= WAIT_R;
                end
                WAIT_R: begin
                    if (r_hs) begin
                        kill  <= 1'b0;
                        state <= ADDR;
                        if (redirect_valid)
                            req_addr <= redirect_pc;
                        else if (kill)
                            req_addr <= pc;
                        else begin
`ifdef IFU_SKID_BUF_EN
                            inst_q <= rdata;
                            pc_q   <= req_addr;
                            snpc_q <= req_addr + 32'd4;
                            err_q  <= (rresp != 2'b00);
                            state  <= HOLD;
`else
                            pc       <= pc + 32'd4;
                            req_addr <= pc + 32'd4;
`endif
                        end
                    end else if (redirect_valid) begin
                        kill <= 1'b1;
                    end
                end
`ifdef IFU_SKID_BUF_EN
                HOLD: begin
                    if (redirect_valid) begin
                        req_addr <= redirect_pc;
                        state    <= ADDR;
                    end else if (m_ready) begin
                        pc       <= pc + 32'd4;
                        req_addr <= pc + 32'd4;
                        state    <= ADDR;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
